// File: rtl/rc4_decrypt_core.sv
// rc4_decrypt_core: RC4 engine (S-box init, key schedule, keystream decrypt)
// driving three external single-port memories that each have a registered
// address and an unregistered q.
// Optional build macro: RC4_ASCII_CHECK_EN. When defined, every plaintext
// byte must be a space or a lowercase letter. The first byte that fails is
// still written, and then the run stops early with key_ok low.
module rc4_decrypt_core #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32,
    parameter int MSG_AW    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    output logic                   key_ok,
    output logic [7:0]             s_address,
    output logic [7:0]             s_data,
    output logic                   s_wren,
    input  logic [7:0]             s_q,
    output logic [MSG_AW-1:0]      m_address,
    input  logic [7:0]             m_q,
    output logic [MSG_AW-1:0]      d_address,
    output logic [7:0]             d_data,
    output logic                   d_wren
);

    typedef enum logic [4:0] {
        ST_IDLE, ST_INIT,
        ST_K0, ST_K1, ST_K2, ST_K3, ST_K4, ST_K5,
        ST_P0, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_P6, ST_P7, ST_P8,
        ST_DONE
    } state_t;

    localparam logic [5:0]        KIDX_LAST = 6'(KEY_BYTES - 1);
    localparam logic [MSG_AW-1:0] K_LAST    = MSG_AW'(MSG_LEN - 1);
    localparam logic [MSG_AW-1:0] K_ONE     = MSG_AW'(1);

`ifdef RC4_ASCII_CHECK_EN
    // Accept only a space or a lowercase letter as a plaintext byte.
    function automatic logic byte_ok(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction
`endif

    state_t                   state_r, state_nxt_s;
    logic [7:0]               i_r, i_nxt_s;
    logic [7:0]               j_r, j_nxt_s;
    logic [MSG_AW-1:0]        k_r, k_nxt_s;
    logic [5:0]               kidx_r, kidx_nxt_s;
    logic [8*KEY_BYTES-1:0]   key_r, key_nxt_s;
    logic [7:0]               si_r, si_nxt_s;
    logic [7:0]               sj_r, sj_nxt_s;
    logic [7:0]               mq_r, mq_nxt_s;
    logic [7:0]               key_byte_s;

    // Registered output copies and their next values.
    logic                     busy_r, busy_nxt_s;
    logic                     done_r, done_nxt_s;
    logic                     key_ok_r, key_ok_nxt_s;
    logic [7:0]               s_address_r, s_address_nxt_s;
    logic [7:0]               s_data_r, s_data_nxt_s;
    logic                     s_wren_r, s_wren_nxt_s;
    logic [MSG_AW-1:0]        m_address_r, m_address_nxt_s;
    logic [MSG_AW-1:0]        d_address_r, d_address_nxt_s;
    logic [7:0]               d_data_r, d_data_nxt_s;
    logic                     d_wren_r, d_wren_nxt_s;

    assign busy      = busy_r;
    assign done      = done_r;
    assign key_ok    = key_ok_r;
    assign s_address = s_address_r;
    assign s_data    = s_data_r;
    assign s_wren    = s_wren_r;
    assign m_address = m_address_r;
    assign d_address = d_address_r;
    assign d_data    = d_data_r;
    assign d_wren    = d_wren_r;

    // Select key byte (i mod KEY_BYTES) using the wrap counter; byte 0 is the MSB byte.
    always_comb begin
        key_byte_s = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_r == 6'(b)) begin
                key_byte_s = key_r[8*(KEY_BYTES-1-b) +: 8];
            end else begin
                key_byte_s = key_byte_s;
            end
        end
    end

    // Next-state and next-output logic. Output registers are loaded on the
    // edge that enters a state, so each state's memory-port values are set
    // by the transition into it.
    always_comb begin
        state_nxt_s     = state_r;
        i_nxt_s         = i_r;
        j_nxt_s         = j_r;
        k_nxt_s         = k_r;
        kidx_nxt_s      = kidx_r;
        key_nxt_s       = key_r;
        si_nxt_s        = si_r;
        sj_nxt_s        = sj_r;
        mq_nxt_s        = mq_r;
        key_ok_nxt_s    = key_ok_r;
        s_address_nxt_s = s_address_r;
        s_data_nxt_s    = s_data_r;
        s_wren_nxt_s    = 1'b0;
        m_address_nxt_s = m_address_r;
        d_address_nxt_s = d_address_r;
        d_data_nxt_s    = d_data_r;
        d_wren_nxt_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    key_nxt_s       = secret_key;
                    key_ok_nxt_s    = 1'b0;
                    i_nxt_s         = 8'd0;
                    j_nxt_s         = 8'd0;
                    k_nxt_s         = '0;
                    kidx_nxt_s      = 6'd0;
                    s_address_nxt_s = 8'd0;
                    s_data_nxt_s    = 8'd0;
                    s_wren_nxt_s    = 1'b1;
                    state_nxt_s     = ST_INIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (i_r == 8'd255) begin
                    i_nxt_s         = 8'd0;
                    s_address_nxt_s = 8'd0;
                    state_nxt_s     = ST_K0;
                end else begin
                    i_nxt_s         = i_r + 8'd1;
                    s_address_nxt_s = i_r + 8'd1;
                    s_data_nxt_s    = i_r + 8'd1;
                    s_wren_nxt_s    = 1'b1;
                    state_nxt_s     = ST_INIT;
                end
            end
            ST_K0: state_nxt_s = ST_K1;
            ST_K1: begin
                si_nxt_s        = s_q;
                j_nxt_s         = j_r + s_q + key_byte_s;
                s_address_nxt_s = j_r + s_q + key_byte_s;
                state_nxt_s     = ST_K2;
            end
            ST_K2: state_nxt_s = ST_K3;
            ST_K3: begin
                sj_nxt_s        = s_q;
                s_address_nxt_s = j_r;
                s_data_nxt_s    = si_r;
                s_wren_nxt_s    = 1'b1;
                state_nxt_s     = ST_K4;
            end
            ST_K4: begin
                s_address_nxt_s = i_r;
                s_data_nxt_s    = sj_r;
                s_wren_nxt_s    = 1'b1;
                state_nxt_s     = ST_K5;
            end
            ST_K5: begin
                i_nxt_s = i_r + 8'd1;
                if (kidx_r == KIDX_LAST) begin
                    kidx_nxt_s = 6'd0;
                end else begin
                    kidx_nxt_s = kidx_r + 6'd1;
                end
                if (i_r == 8'd255) begin
                    // Key schedule finished: keystream phase starts at i=1, j=0.
                    j_nxt_s         = 8'd0;
                    s_address_nxt_s = 8'd1;
                    state_nxt_s     = ST_P0;
                end else begin
                    s_address_nxt_s = i_r + 8'd1;
                    state_nxt_s     = ST_K0;
                end
            end
            ST_P0: begin
                i_nxt_s     = i_r + 8'd1;
                state_nxt_s = ST_P1;
            end
            ST_P1: begin
                si_nxt_s        = s_q;
                j_nxt_s         = j_r + s_q;
                s_address_nxt_s = j_r + s_q;
                state_nxt_s     = ST_P2;
            end
            ST_P2: state_nxt_s = ST_P3;
            ST_P3: begin
                sj_nxt_s        = s_q;
                s_address_nxt_s = i_r;
                s_data_nxt_s    = s_q;
                s_wren_nxt_s    = 1'b1;
                state_nxt_s     = ST_P4;
            end
            ST_P4: begin
                s_address_nxt_s = j_r;
                s_data_nxt_s    = si_r;
                s_wren_nxt_s    = 1'b1;
                m_address_nxt_s = k_r;
                state_nxt_s     = ST_P5;
            end
            ST_P5: begin
                s_address_nxt_s = si_r + sj_r;
                state_nxt_s     = ST_P6;
            end
            ST_P6: begin
                mq_nxt_s    = m_q;
                state_nxt_s = ST_P7;
            end
            ST_P7: begin
                // s_q carries the keystream byte f here; the XOR goes straight into the write data.
                d_address_nxt_s = k_r;
                d_data_nxt_s    = s_q ^ mq_r;
                d_wren_nxt_s    = 1'b1;
                state_nxt_s     = ST_P8;
            end
            ST_P8: begin
`ifdef RC4_ASCII_CHECK_EN
                if (!byte_ok(d_data_r)) begin
                    key_ok_nxt_s = 1'b0;
                    state_nxt_s  = ST_DONE;
                end else if (k_r == K_LAST) begin
                    key_ok_nxt_s = 1'b1;
                    state_nxt_s  = ST_DONE;
                end else begin
                    k_nxt_s         = k_r + K_ONE;
                    s_address_nxt_s = i_r + 8'd1;
                    state_nxt_s     = ST_P0;
                end
`else
                if (k_r == K_LAST) begin
                    key_ok_nxt_s = 1'b1;
                    state_nxt_s  = ST_DONE;
                end else begin
                    k_nxt_s         = k_r + K_ONE;
                    s_address_nxt_s = i_r + 8'd1;
                    state_nxt_s     = ST_P0;
                end
`endif
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase

        done_nxt_s = (state_nxt_s == ST_DONE);
        busy_nxt_s = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
    end

    // State register with synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers; reset forces every output low.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_r         <= 8'd0;
            j_r         <= 8'd0;
            k_r         <= '0;
            kidx_r      <= 6'd0;
            key_r       <= '0;
            si_r        <= 8'd0;
            sj_r        <= 8'd0;
            mq_r        <= 8'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            key_ok_r    <= 1'b0;
            s_address_r <= 8'd0;
            s_data_r    <= 8'd0;
            s_wren_r    <= 1'b0;
            m_address_r <= '0;
            d_address_r <= '0;
            d_data_r    <= 8'd0;
            d_wren_r    <= 1'b0;
        end else begin
            i_r         <= i_nxt_s;
            j_r         <= j_nxt_s;
            k_r         <= k_nxt_s;
            kidx_r      <= kidx_nxt_s;
            key_r       <= key_nxt_s;
            si_r        <= si_nxt_s;
            sj_r        <= sj_nxt_s;
            mq_r        <= mq_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            key_ok_r    <= key_ok_nxt_s;
            s_address_r <= s_address_nxt_s;
            s_data_r    <= s_data_nxt_s;
            s_wren_r    <= s_wren_nxt_s;
            m_address_r <= m_address_nxt_s;
            d_address_r <= d_address_nxt_s;
            d_data_r    <= d_data_nxt_s;
            d_wren_r    <= d_wren_nxt_s;
        end
    end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// tb_rc4_decrypt_core: two engine instances (3-byte key / 9-byte message and
// 4-byte key / 5-byte message) with behavioural memories; expected plaintext
// writes are queued per run and popped as the engine writes D.
module tb_rc4_decrypt_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: KEY_BYTES=3, MSG_LEN=9
    logic        reset_a, start_a, busy_a, done_a, key_ok_a, s_wren_a, d_wren_a;
    logic [23:0] key_a;
    logic [7:0]  s_address_a, s_data_a, s_q_a, m_q_a, d_data_a;
    logic [3:0]  m_address_a, d_address_a;
    // Instance B: KEY_BYTES=4, MSG_LEN=5
    logic        reset_b, start_b, busy_b, done_b, key_ok_b, s_wren_b, d_wren_b;
    logic [31:0] key_b;
    logic [7:0]  s_address_b, s_data_b, s_q_b, m_q_b, d_data_b;
    logic [2:0]  m_address_b, d_address_b;

    rc4_decrypt_core #(.KEY_BYTES(3), .MSG_LEN(9), .MSG_AW(4)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .secret_key(key_a),
        .busy(busy_a), .done(done_a), .key_ok(key_ok_a),
        .s_address(s_address_a), .s_data(s_data_a), .s_wren(s_wren_a), .s_q(s_q_a),
        .m_address(m_address_a), .m_q(m_q_a),
        .d_address(d_address_a), .d_data(d_data_a), .d_wren(d_wren_a)
    );

    rc4_decrypt_core #(.KEY_BYTES(4), .MSG_LEN(5), .MSG_AW(3)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .secret_key(key_b),
        .busy(busy_b), .done(done_b), .key_ok(key_ok_b),
        .s_address(s_address_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
        .m_address(m_address_b), .m_q(m_q_b),
        .d_address(d_address_b), .d_data(d_data_b), .d_wren(d_wren_b)
    );

    // Memories: registered address, unregistered q.
    logic [7:0] s_mem_a [256];
    logic [7:0] s_mem_b [256];
    logic [7:0] rom_a [16];
    logic [7:0] rom_b [8];
    logic [7:0] d_ram_a [16];
    logic [7:0] d_ram_b [8];
    logic [7:0] s_aq_a, s_aq_b;
    logic [3:0] m_aq_a;
    logic [2:0] m_aq_b;

    // Memory model for instance A.
    always @(posedge clk) begin
        s_aq_a <= s_address_a;
        m_aq_a <= m_address_a;
        if (s_wren_a) s_mem_a[s_address_a] <= s_data_a;
        if (d_wren_a) d_ram_a[d_address_a] <= d_data_a;
    end

    // Memory model for instance B.
    always @(posedge clk) begin
        s_aq_b <= s_address_b;
        m_aq_b <= m_address_b;
        if (s_wren_b) s_mem_b[s_address_b] <= s_data_b;
        if (d_wren_b) d_ram_b[d_address_b] <= d_data_b;
    end

    assign s_q_a = s_mem_a[s_aq_a];
    assign s_q_b = s_mem_b[s_aq_b];
    assign m_q_a = rom_a[m_aq_a];
    assign m_q_b = rom_b[m_aq_b];

    // Instance selected by the directed steps (0 = A, 1 = B).
    logic sel;
    wire        busy_m    = sel ? busy_b   : busy_a;
    wire        done_m    = sel ? done_b   : done_a;
    wire        key_ok_m  = sel ? key_ok_b : key_ok_a;
    wire        d_wren_m  = sel ? d_wren_b : d_wren_a;
    wire [7:0]  d_addr_m  = sel ? {5'd0, d_address_b} : {4'd0, d_address_a};
    wire [7:0]  d_data_m  = sel ? d_data_b : d_data_a;
    wire [44:0] outs_a = {busy_a, done_a, key_ok_a, s_wren_a, d_wren_a, s_address_a, s_data_a,
                          4'd0, m_address_a, 4'd0, d_address_a, d_data_a};
    wire [44:0] outs_b = {busy_b, done_b, key_ok_b, s_wren_b, d_wren_b, s_address_b, s_data_b,
                          5'd0, m_address_b, 5'd0, d_address_b, d_data_b};
    wire [44:0] outs_m = sel ? outs_b : outs_a;

    // Scoreboard of expected D writes: {address, data}.
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic push_str(input string s, input int n);
        for (int p = 0; p < n; p++) exp_q.push_back({8'(p), 8'(s[p])});
    endtask

    function automatic int init_bad();
        int n = 0;
        for (int a = 0; a < 256; a++) begin
            if ((sel ? s_mem_b[a] : s_mem_a[a]) !== 8'(a)) n++;
        end
        return n;
    endfunction

    // Start a run from a negedge in IDLE, check each D write against the
    // scoreboard, then check latency, key_ok and that every write arrived.
    task automatic run(input string tag, input int exp_lat, input logic exp_ok,
                       input bit poke, input bit chk_init);
        int cyc;
        logic [15:0] e;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        cyc = 1;
        check({tag, "_busy"}, busy_m, 1'b1);
        while (done_m !== 1'b1 && cyc < 4000) begin
            if (d_wren_m === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
                check({tag, "_dwrite"}, {d_addr_m, d_data_m}, e);
            end
            if (chk_init && cyc == 257) check({tag, "_init_s"}, init_bad(), 0);
            if (poke && (cyc == 10 || cyc == 500)) begin
                set_start(1'b1);
                key_b = 32'h4E6F7065;
            end else begin
                set_start(1'b0);
            end
            @(negedge clk);
            cyc++;
        end
        set_start(1'b0);
        check({tag, "_done_seen"}, done_m, 1'b1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_key_ok"}, key_ok_m, exp_ok);
        check({tag, "_writes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int dn;
        logic [7:0] ct_a [9];
        logic [7:0] ct_b [5];
        ct_a = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        ct_b = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
        for (int a = 0; a < 16; a++) rom_a[a] = (a < 9) ? ct_a[a] : 8'h00;
        for (int a = 0; a < 8; a++)  rom_b[a] = (a < 5) ? ct_b[a] : 8'h00;
        sel = 1'b0;
        reset_a = 1'b1; reset_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        key_a = 24'h4B6579;
        key_b = 32'h57696B69;
        repeat (3) @(negedge clk);
        sel = 1'b0; check("reset_outs_a", outs_m, 45'd0);
        sel = 1'b1; check("reset_outs_b", outs_m, 45'd0);
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);

        // "Key" decrypts the ROM to "Plaintext".
        sel = 1'b0;
`ifdef RC4_ASCII_CHECK_EN
        push_str("P", 1);
        run("key_plaintext", 1802, 1'b0, 1'b0, 1'b0);
`else
        push_str("Plaintext", 9);
        run("key_plaintext", 1874, 1'b1, 1'b0, 1'b0);
`endif

        // "Wiki" decrypts to "pedia"; S must hold 0..255 right after INIT.
        sel = 1'b1;
        push_str("pedia", 5);
        run("wiki_pedia", 1838, 1'b1, 1'b0, 1'b1);
        // Start during the done cycle is ignored; key_ok holds in IDLE.
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("start_on_done_ignored", busy_m, 1'b0);
        check("key_ok_held", key_ok_m, 1'b1);
        // Back-to-back start, with extra starts and a key change mid-run.
        push_str("pedia", 5);
        run("b2b_double_start", 1838, 1'b1, 1'b1, 1'b0);
        key_b = 32'h57696B69;
        @(negedge clk);

        // Reset mid-KSA with a coincident start, then rerun.
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (699) @(negedge clk);
        reset_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        check("reset_mid_ksa_outs", outs_m, 45'd0);
        reset_b = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check("start_with_reset_ignored", busy_m, 1'b0);
        dn = 0;
        repeat (2100) begin
            @(negedge clk);
            if (done_m === 1'b1) dn++;
        end
        check("no_done_after_reset", dn, 0);
        push_str("pedia", 5);
        run("rerun_after_reset", 1838, 1'b1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc4_decrypt_core.md
# rc4_decrypt_core

Parametrised RC4 engine: on `start` it initialises the 256-byte S memory, runs the key-scheduling algorithm with a `KEY_BYTES`-byte secret key, then decrypts `MSG_LEN` bytes from the encrypted-message ROM into the decrypted-message RAM. It supersedes the fixed 24-bit-key, 32-byte shuffle/decrypt FSM pair. It sits between the top level, which owns the three single-port memories and the key source (switches or a key-search sequencer), and those memories.

## Interface
Parameters:
- `KEY_BYTES`, 3: secret key length in bytes, 1..32.
- `MSG_LEN`, 32: message length in bytes, 1..256.
- `MSG_AW`, 5: message address width, ≥ clog2(MSG_LEN).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock (CLOCK_50)
  - `reset`  in  1  synchronous, active-high
- Control:
  - `start`  in  1  one-cycle pulse; ignored unless idle
  - `secret_key`  in  8*KEY_BYTES  sampled on accepted `start`; byte 0 is the MSB byte
  - `busy`  out  1  high from accepted start until done
  - `done`  out  1  one-cycle pulse at completion
  - `key_ok`  out  1  result flag, valid at `done` and held until next start (see Configuration)
- S memory:
  - `s_address`  out  8
  - `s_data`  out  8
  - `s_wren`  out  1
  - `s_q`  in  8
- Encrypted-message ROM:
  - `m_address`  out  MSG_AW
  - `m_q`  in  8
- Decrypted-message RAM:
  - `d_address`  out  MSG_AW
  - `d_data`  out  8
  - `d_wren`  out  1

## Operation
- All memories have a registered address and unregistered q. A read address driven in cycle n gives q valid in cycle n+1.
- IDLE: wait for `start`. On `start`, latch the key and clear `key_ok`, i, j and k.
- INIT: 256 cycles, writing S[i]=i for i=0..255.
- KSA: for i=0..255, six cycles per i:
  - K0: address i.
  - K1: si←s_q; j←j+si+key[i mod KEY_BYTES].
  - K2: address j.
  - K3: sj←s_q.
  - K4: write S[j]←si.
  - K5: write S[i]←sj.
  - Clear j when KSA ends.
- PRGA: for k=0..MSG_LEN-1, nine cycles per k:
  - P0: i←i+1, address i+1.
  - P1: si←s_q; j←j+si.
  - P2: address j.
  - P3: sj←s_q.
  - P4: write S[i]←sj.
  - P5: write S[j]←si; m_address←k.
  - P6: address si+sj; mq←m_q.
  - P7: f←s_q.
  - P8: write d[k]←f^mq.
- DONE: one cycle; pulse `done`, drop `busy`, return to IDLE.
- Arithmetic rules:
  - All i, j and S index arithmetic is 8-bit modulo 256.
  - i==j is legal: the two writes carry the same value, and S stays correct.
  - key index (i mod KEY_BYTES) uses a wrap counter, not a divider.
- `s_wren` and `d_wren` are high only in the write cycles listed above.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset in any state returns to IDLE on the next edge. S and D contents are then undefined, and `done` does not pulse.
- Latency from the accepted `start` edge to the `done` pulse: 256 + 1536 + 9·MSG_LEN + 1 cycles. With default parameters this is 2081 cycles.
- `start` while busy is ignored.
- `start` on the same cycle as the `done` pulse is ignored.
- `start` coincident with `reset` is ignored.
- `secret_key` changes after acceptance have no effect.
- Back-to-back runs: `start` in the first IDLE cycle after `done` is accepted.

## Configuration
- `RC4_ASCII_CHECK_EN` defined:
  - In P8, the plaintext byte must be 8'h20 or in 8'h61..8'h7A.
  - The first byte outside that range still gets written, then the FSM goes straight to DONE (early abort) with `key_ok`=0.
  - `key_ok`=1 only if all MSG_LEN bytes pass.
- Macro undefined:
  - No check and no abort; latency is always the full value.
  - `key_ok` is 1 at every `done`.

## Test plan
- KEY_BYTES=3, key 24'h4B6579 ("Key"), MSG_LEN=9, ROM BB F3 16 E8 D9 40 AF 0A D3:
  - D = 50 6C 61 69 6E 74 65 78 74 ("Plaintext").
  - Macro off: `done` 256+1536+81+1=1874 cycles after start, `key_ok`=1.
  - Macro on: abort after byte 0 ('P'), `key_ok`=0, `done` 256+1536+9+1=1802 cycles after start.
- KEY_BYTES=4, key 32'h57696B69 ("Wiki"), MSG_LEN=5, ROM 10 21 BF 04 20 -> D = "pedia", `key_ok`=1 with the macro on.
- KEY_BYTES=6, key "Secret", MSG_LEN=14, ROM 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5 -> D = "Attack at dawn". Macro on: abort at byte 0 ('A'), `key_ok`=0.
- Assert `reset` mid-KSA (cycle 700), then `start` "Wiki":
  - Outputs 0 the cycle after reset.
  - The rerun yields "pedia".
  - No `done` pulse from the aborted run.
- Pulse `start` at cycles 10 and 500 of a run, then with a different key: second pulse ignored, result and latency match a single-start run.
- Check INIT writes: S[0..255] = 0..255 after cycle 256.
